// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle between a requester and serial_subtractor.
// Carries the start request, both operands, status strobes and the registered results.
// The master drives the request side; the slave (the subtractor) drives status and results.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, diff, borrow, zero, ovf
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: minuend - subtrahend, LSB first, one full-subtractor cell.
// Latency: WIDTH edges from the accepting edge to the done pulse; one IDLE cycle before the next accept.
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped, not queued.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers, partial result and serial borrow
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    count;
  logic             br;

  // Registered results, held between done pulses
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, zero_q, ovf_q;

  // Status strobes decoded from state only
  logic busy_o, done_o;

  // Full-subtractor cell on the current bit pair
  logic             a_bit, b_bit, d_bit, br_nxt, last_bit;
  logic [WIDTH-1:0] res_nxt;

  assign a_bit    = sa[0];
  assign b_bit    = sb[0];
  assign d_bit    = a_bit ^ b_bit ^ br;
  assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign res_nxt  = {d_bit, res[WIDTH-1:1]};
  assign last_bit = (count == LAST_BIT);

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state, so no input reaches them combinationally
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      RUN:     busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN edge, commit results on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      count    <= '0;
      br       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.minuend;
            sb    <= bus.subtrahend;
            res   <= '0;
            count <= '0;
            br    <= 1'b0;
          end
        end
        RUN: begin
          res   <= res_nxt;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          br    <= br_nxt;
          count <= count + CW'(1);
          if (last_bit) begin
            // On the last bit a_bit/b_bit are the operand sign bits and d_bit is the result sign
            diff_q   <= res_nxt;
            borrow_q <= br_nxt;
            zero_q   <= (res_nxt == '0);
            ovf_q    <= (a_bit != b_bit) & (d_bit != a_bit);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_o;
  assign bus.done   = done_o;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;

endmodule
